// File: rtl/mmio_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_uart_tx
//  Purpose  : Memory-mapped 8N1 UART transmitter with a small transmit FIFO.
//             TXDATA (BASE_ADDR) accepts bytes on store; STATUS (BASE_ADDR+4)
//             reports {count, overflow, busy, empty, full} and lets the core
//             clear the sticky overflow flag by writing bit 3.
//  Ports    : clk   - single clock, rising edge
//             rst   - asynchronous, active-low reset
//             daddr - core data-bus byte address
//             din   - core store data
//             dwe   - core store strobe
//             dout  - combinational load data (0 when not hit)
//             hit   - daddr selects TXDATA or STATUS
//             tx    - serial line, idle high
//             busy  - frame in flight or FIFO non-empty
//  Revision : 1.0  initial release
// ============================================================================
module mmio_uart_tx #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h0000_F000,
    parameter int                    CLKS_PER_BIT = 434,
    parameter int                    FIFO_DEPTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  dwe,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  hit,
    output logic                  tx,
    output logic                  busy
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam int c_tmr_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_tmr_w-1:0]    c_tmr_last    = c_tmr_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0]    c_depth       = c_cnt_w'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] c_status_addr = BASE_ADDR + DATA_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t               r_state;
    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_overflow;
    logic [c_tmr_w-1:0]   r_tmr;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_tx;

    logic                 w_hit_tx;
    logic                 w_hit_st;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_ovf_set;
    logic                 w_ovf_clr;
    logic                 w_tmr_done;
    logic                 w_line;
    logic [7:0]           w_cnt_ext;
    logic [7:0]           w_status;
    logic                 w_unused;

    // ------------------------------------------------------------------
    // Bus decode and status read-back (read has no side effects)
    // ------------------------------------------------------------------
    assign w_hit_tx  = (daddr == BASE_ADDR);
    assign w_hit_st  = (daddr == c_status_addr);
    assign hit       = w_hit_tx | w_hit_st;

    assign w_full    = (r_count == c_depth);
    assign w_empty   = (r_count == '0);
    assign busy      = (r_state != S_IDLE) | ~w_empty;

    assign w_cnt_ext = 8'(r_count);
    assign w_status  = {w_cnt_ext[3:0], r_overflow, busy, w_empty, w_full};
    assign dout      = w_hit_st ? DATA_WIDTH'(w_status) : '0;

    assign w_unused  = ^din[DATA_WIDTH-1:8];

    // Fullness is judged before the edge, so a pop on the same edge never
    // rescues a push into a full FIFO.
    assign w_push     = dwe & w_hit_tx & ~w_full;
    assign w_ovf_set  = dwe & w_hit_tx &  w_full;
    assign w_ovf_clr  = dwe & w_hit_st &  din[3];

    assign w_tmr_done = (r_tmr == c_tmr_last);

    // The FSM takes the head byte when idle, or at the very end of a stop
    // bit so that queued frames follow each other with no idle gap.
    assign w_pop = ~w_empty &
                   ((r_state == S_IDLE) | ((r_state == S_STOP) & w_tmr_done));

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
            // Setting wins over a simultaneous clear.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (w_ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM. tx is registered from the current state's line level,
    // so the line lags the state by one cycle; every bit still lasts
    // exactly CLKS_PER_BIT cycles.
    // ------------------------------------------------------------------
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            S_START: w_line = 1'b0;
            S_DATA:  w_line = r_shift[r_bit_idx];
            default: w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            r_tx <= w_line;
            case (r_state)
                S_IDLE: begin
                    r_tmr     <= '0;
                    r_bit_idx <= 3'd0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_tmr_done) begin
                        r_tmr     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= S_DATA;
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                S_DATA: begin
                    if (w_tmr_done) begin
                        r_tmr <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= 3'd0;
                            r_state   <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                S_STOP: begin
                    if (w_tmr_done) begin
                        r_tmr <= '0;
                        if (w_pop) begin
                            r_shift <= r_mem[r_rd_ptr];
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_tmr <= r_tmr + c_tmr_w'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tmr   <= '0;
                end
            endcase
        end
    end

    assign tx = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mmio_uart_tx
//  Purpose  : Directed self-checking bench for mmio_uart_tx with
//             CLKS_PER_BIT=4 and FIFO_DEPTH=4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] c_base = 32'h0000_F000;
    localparam logic [31:0] c_stat = 32'h0000_F004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] daddr = c_stat;
    logic [31:0] din = 32'h0;
    logic        dwe = 1'b0;
    logic [31:0] dout;
    logic        hit;
    logic        tx;
    logic        busy;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  frame_q [4];

    mmio_uart_tx #(
        .DATA_WIDTH   (32),
        .BASE_ADDR    (32'h0000_F000),
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .daddr (daddr),
        .din   (din),
        .dwe   (dwe),
        .dout  (dout),
        .hit   (hit),
        .tx    (tx),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Expected line level sampled after the k-th rising edge counted from
    // the first push edge (k=0), for n back-to-back queued frames.
    // Line falls two edges after the first push; each frame is 40 cycles:
    // 4 start, 32 data (LSB first), 4 stop.
    function automatic logic exp_line(input int n, input int k);
        int j;
        int m;
        logic [7:0] b;
        if (k < 2) return 1'b1;
        j = (k - 2) / 40;
        m = (k - 2) % 40;
        if (j >= n) return 1'b1;
        if (m < 4) return 1'b0;
        if (m < 36) begin
            b = frame_q[j];
            return b[(m - 4) / 4];
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        dwe   = 1'b0;
        daddr = c_stat;
        din   = 32'h0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        rst   = 1'b1;
    endtask

    // Push frame_q[0..n-1] on consecutive edges and check tx/busy every cycle.
    task automatic send_and_watch(input int n, input string name);
        for (int k = 0; k <= 40 * n + 3; k++) begin
            if (k < n) begin
                dwe = 1'b1; daddr = c_base; din = {24'h0, frame_q[k]};
            end else begin
                dwe = 1'b0; daddr = c_stat; din = 32'h0;
            end
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_tx_k%0d", name, k), {31'b0, tx}, {31'b0, exp_line(n, k)});
            check($sformatf("%s_busy_k%0d", name, k), {31'b0, busy},
                  (k <= 40 * n) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_tx", {31'b0, tx}, 32'd1);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_hit_status", {31'b0, hit}, 32'd1);
        check("rst_status", dout, 32'h2);
        do_reset();

        // Single frame 0xA5
        frame_q[0] = 8'hA5;
        send_and_watch(1, "a5");

        // Three contiguous frames
        frame_q[0] = 8'h01; frame_q[1] = 8'h02; frame_q[2] = 8'h03;
        send_and_watch(3, "b2b");

        // Fill during a frame: 0x11 starts, then 0x22..0x55 queue, 0x66 drops
        do_reset();
        for (int j = 0; j < 6; j++) begin
            dwe = 1'b1; daddr = c_base; din = 32'h11 * (j + 1);
            @(posedge clk);
            @(negedge clk);
        end
        dwe = 1'b0; daddr = c_stat; din = 32'h0;
        #1;
        check("full_hit", {31'b0, hit}, 32'd1);
        check("full_status", dout, 32'h4D);
        dwe = 1'b1; din = 32'h8;
        @(negedge clk);
        dwe = 1'b0; din = 32'h0;
        #1;
        check("ovf_clear_status", dout, 32'h45);
        daddr = c_base;
        #1;
        check("txdata_hit", {31'b0, hit}, 32'd1);
        check("txdata_read", dout, 32'h0);

        // Push into full FIFO on the edge the FSM pops (edge 41 of this run)
        repeat (34) @(negedge clk);
        daddr = c_stat;
        #1;
        check("pre_pop_status", dout, 32'h45);
        dwe = 1'b1; daddr = c_base; din = 32'h77;
        @(negedge clk);
        dwe = 1'b0; daddr = c_stat; din = 32'h0;
        #1;
        check("pop_push_status", dout, 32'h3C);
        check("pop_push_tx", {31'b0, tx}, 32'd1);

        // Asynchronous reset in the middle of the data bits of frame 0x22
        repeat (15) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_tx", {31'b0, tx}, 32'd1);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_status", dout, 32'h2);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle_k%0d", k), {30'b0, tx, busy}, 32'h2);
        end
        check("post_rst_status", dout, 32'h2);

        // Off-map write: no hit, no effect
        daddr = c_base + 32'h8; dwe = 1'b1; din = 32'h55;
        #1;
        check("offmap_hit", {31'b0, hit}, 32'd0);
        check("offmap_dout", dout, 32'h0);
        @(negedge clk);
        dwe = 1'b0; daddr = c_stat; din = 32'h0;
        #1;
        check("offmap_status", dout, 32'h2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("offmap_tx_k%0d", k), {31'b0, tx}, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data-bus address and data width.
REQ-002 Parameter BASE_ADDR, default 32'h0000_F000, SHALL set the byte address of TXDATA; STATUS SHALL be at BASE_ADDR+4.
REQ-003 Parameter CLKS_PER_BIT, default 434, SHALL set the clk cycles per serial bit (50 MHz / 115200).
REQ-004 Parameter FIFO_DEPTH, default 8, power of two, >=2, SHALL set the transmit FIFO depth.
REQ-005 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 daddr  input  DATA_WIDTH  core data-bus byte address.
REQ-008 din  input  DATA_WIDTH  core store data (core ddout).
REQ-009 dwe  input  1  core store strobe, sampled at the rising edge.
REQ-010 dout  output  DATA_WIDTH  read data for the core load path.
REQ-011 hit  output  1  high while daddr equals BASE_ADDR or BASE_ADDR+4.
REQ-012 tx  output  1  serial line, 8N1, idle high.
REQ-013 busy  output  1  high while a frame is shifting or the FIFO is non-empty.

Function
REQ-014 hit and dout SHALL be combinational from daddr and current state; read has no side effects.
REQ-015 dout at STATUS SHALL be {zeros, count[7:4], overflow[3], busy[2], empty[1], full[0]}; at TXDATA SHALL be 0; when hit is low it SHALL be 0.
REQ-016 dwe=1 with daddr=BASE_ADDR SHALL push din[7:0] into the FIFO at that edge if the FIFO was not full before the edge.
REQ-017 A push to a FIFO full before the edge SHALL be dropped and SHALL set the sticky overflow flag, even if a pop occurs on the same edge.
REQ-018 dwe=1 with daddr=BASE_ADDR+4 and din[3]=1 SHALL clear overflow; other STATUS bits are read-only; if the same edge sets and clears, set SHALL win.
REQ-019 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH; full = (count==FIFO_DEPTH), empty = (count==0).
REQ-020 Transmit FSM states: IDLE, START, DATA, STOP.
REQ-021 IDLE with FIFO non-empty SHALL pop the head byte into the shift register and enter START at that edge; tx SHALL be 0 from the following cycle.
REQ-022 START, each DATA bit and STOP SHALL each hold tx for exactly CLKS_PER_BIT cycles, counted by a bit-timer reset on every state or bit change.
REQ-023 DATA SHALL send 8 bits, LSB first, using a 3-bit index; after bit 7 the FSM SHALL enter STOP with tx=1.
REQ-024 At the end of STOP the FSM SHALL enter IDLE; if the FIFO is non-empty at that edge it SHALL instead pop and enter START directly, so back-to-back frames have no idle gap.
REQ-025 A frame SHALL last exactly 10*CLKS_PER_BIT cycles; push-edge to tx falling edge SHALL be 2 cycles when IDLE and FIFO empty.
REQ-026 Simultaneous push and pop SHALL leave count unchanged and store the pushed byte.

Reset
REQ-027 rst=0 SHALL immediately, independent of clk, set FSM=IDLE, tx=1, busy=0, FIFO count and pointers=0, overflow=0, bit-timer=0, bit index=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame at once (tx=1); queued bytes SHALL be discarded.
REQ-029 After rst releases, the first push SHALL be accepted on the first rising edge with rst=1.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Reset, then write 0xA5 to TXDATA -> tx low 2 cycles later; bits 1,0,1,0,0,1,0,1 each 4 cycles; stop high 4 cycles; busy low after 40 cycles.
REQ-031 Write 0x01, 0x02, 0x03 on consecutive cycles -> three contiguous 40-cycle frames, no gap between stop and next start.
REQ-032 With frame in progress, write 5 bytes -> 4 in FIFO, 5th dropped; STATUS reads full=1, overflow=1, count=4; writing STATUS with din=0x8 -> overflow=0.
REQ-033 Write to full FIFO on the same edge the FSM pops -> write dropped, overflow=1, count goes 4->3.
REQ-034 Assert rst=0 mid-DATA between clk edges -> tx=1, busy=0, STATUS=0x2 immediately; no residual frame after release.
REQ-035 daddr=BASE_ADDR+8 with dwe=1 -> hit=0, dout=0, FIFO and tx unchanged.
